// File: rtl/mdu_ctrl.sv
// mdu_ctrl: HI/LO multiply/divide sequencer; busy MULT_LAT (mult) or DIV_LAT (div) cycles, mthi/mtlo immediate.
// No backpressure: start is ignored while busy (hazard unit stalls); defining MDU_MADD_EN adds madd/msub.
module mdu_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        flush,
    input  logic [3:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MSUB  = 4'd8;
`endif

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      op_q, op_d;
    logic [31:0]     a_q, a_d;
    logic [31:0]     b_q, b_d;
    logic [31:0]     hi_q, hi_d;
    logic [31:0]     lo_q, lo_d;

    logic            accept;
    logic [63:0]     prod_s;
    logic [63:0]     prod_u;
    logic            a_neg, b_neg;
    logic [31:0]     a_mag, b_mag;
    logic [31:0]     q_mag, r_mag;
    logic [31:0]     quot, rem;
`ifdef MDU_MADD_EN
    logic [63:0]     acc_add, acc_sub;
`endif

    function automatic logic is_long(input logic [3:0] o);
        case (o)
            4'd1, 4'd2, 4'd3, 4'd4: is_long = 1'b1;
`ifdef MDU_MADD_EN
            4'd7, 4'd8:             is_long = 1'b1;
`endif
            default:                is_long = 1'b0;
        endcase
    endfunction

    // Results are computed from the latched operands; only the commit edge uses them.
    assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};

    // Signed divide via magnitudes: 0x80000000 / -1 wraps back to 0x80000000 with no special case.
    assign a_neg = (op_q == OP_DIV) && a_q[31];
    assign b_neg = (op_q == OP_DIV) && b_q[31];
    assign a_mag = a_neg ? (~a_q + 32'd1) : a_q;
    assign b_mag = b_neg ? (~b_q + 32'd1) : b_q;
    assign q_mag = (b_mag != 32'd0) ? (a_mag / b_mag) : 32'd0;
    assign r_mag = (b_mag != 32'd0) ? (a_mag % b_mag) : 32'd0;
    assign quot  = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    assign rem   = a_neg ? (~r_mag + 32'd1) : r_mag;

`ifdef MDU_MADD_EN
    assign acc_add = {hi_q, lo_q} + prod_s;
    assign acc_sub = {hi_q, lo_q} - prod_s;
`endif

    assign accept = start && !flush && (state_q == S_IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (op == OP_MTHI) begin
                        hi_d = A;
                    end else if (op == OP_MTLO) begin
                        lo_d = A;
                    end else if (is_long(op)) begin
                        state_d = S_BUSY;
                        op_d    = op;
                        a_d     = A;
                        b_d     = B;
                        cnt_d   = ((op == OP_DIV) || (op == OP_DIVU)) ? CW'(DIV_LAT) : CW'(MULT_LAT);
                    end
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_IDLE;
                    case (op_q)
                        OP_MULT:  {hi_d, lo_d} = prod_s;
                        OP_MULTU: {hi_d, lo_d} = prod_u;
                        OP_DIV, OP_DIVU: begin
                            // Divide by zero still spends the full latency but leaves HI/LO alone.
                            if (b_q != 32'd0) begin
                                hi_d = rem;
                                lo_d = quot;
                            end
                        end
`ifdef MDU_MADD_EN
                        OP_MADD:  {hi_d, lo_d} = acc_add;
                        OP_MSUB:  {hi_d, lo_d} = acc_sub;
`endif
                        default: ;
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= 4'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q == S_BUSY);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: directed ops push expected HI/LO; a negedge monitor checks them.
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        flush;
    logic [3:0]  op;
    logic [31:0] a_s;
    logic [31:0] b_s;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    always #5 clk = ~clk;

    mdu_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .flush (flush),
        .op    (op),
        .A     (a_s),
        .B     (b_s),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic [7:0]  len;
    } exp_t;

    exp_t  fall_q[$];
    string fall_n[$];
    exp_t  snap_q[$];
    string snap_n[$];

    int tests = 0;
    int fails = 0;
    int blen  = 0;
    logic busy_prev = 1'b0;

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: commit checks when busy falls, snapshot checks for zero-latency effects.
    always @(negedge clk) begin
        exp_t  e;
        string n;
        if (busy === 1'b1) begin
            blen++;
        end else begin
            if (busy_prev) begin
                if (fall_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_busy_fall: got hi=0x%08h lo=0x%08h expected no commit", hi, lo);
                end else begin
                    e = fall_q.pop_front();
                    n = fall_n.pop_front();
                    check32({n, "_hi"}, hi, e.hi);
                    check32({n, "_lo"}, lo, e.lo);
                    check32({n, "_busy_cycles"}, blen, {24'd0, e.len});
                end
            end
            blen = 0;
        end
        busy_prev = (busy === 1'b1);
        if (snap_q.size() > 0) begin
            e = snap_q.pop_front();
            n = snap_n.pop_front();
            check32({n, "_hi"}, hi, e.hi);
            check32({n, "_lo"}, lo, e.lo);
            check32({n, "_busy"}, {31'd0, busy}, 32'd0);
        end
    end

    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input logic fl);
        op    = o;
        a_s   = a;
        b_s   = b;
        start = 1'b1;
        flush = fl;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
    endtask

    task automatic expect_fall(input string nm, input logic [31:0] h, input logic [31:0] l, input logic [7:0] len);
        exp_t e;
        e.hi = h;
        e.lo = l;
        e.len = len;
        fall_q.push_back(e);
        fall_n.push_back(nm);
    endtask

    task automatic expect_snap(input string nm, input logic [31:0] h, input logic [31:0] l);
        exp_t e;
        e.hi = h;
        e.lo = l;
        e.len = 8'd0;
        snap_q.push_back(e);
        snap_n.push_back(nm);
    endtask

    // Returns in the first cycle busy is low, so the next issue is back-to-back.
    task automatic wait_idle(input string nm);
        int n = 0;
        while (busy !== 1'b0 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL %s_timeout: busy=%b after %0d cycles, required 0", nm, busy, n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op    = 4'd0;
        a_s   = 32'd0;
        b_s   = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        expect_snap("reset_state", 32'h0, 32'h0);
        @(posedge clk);
        #1;

        issue(4'd5, 32'h0000_00AA, 32'h0, 1'b0);
        expect_snap("mthi_aa", 32'h0000_00AA, 32'h0);
        issue(4'd6, 32'h0000_00BB, 32'h0, 1'b0);
        expect_snap("mtlo_bb", 32'h0000_00AA, 32'h0000_00BB);

        // Reset three cycles into a divide: busy drops, HI/LO clear, nothing commits later.
        issue(4'd3, 32'd100, 32'd7, 1'b0);
        expect_fall("reset_mid_div", 32'h0, 32'h0, 8'd3);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        expect_snap("no_commit_after_reset", 32'h0, 32'h0);
        @(posedge clk);
        #1;

        issue(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        expect_fall("mult_m2x3", 32'hFFFF_FFFF, 32'hFFFF_FFFA, 8'd5);
        wait_idle("mult_m2x3");
        issue(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
        expect_fall("multu_max_x2", 32'h0000_0001, 32'hFFFF_FFFE, 8'd5);
        wait_idle("multu_max_x2");
        issue(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        expect_fall("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 8'd10);
        wait_idle("div_m7_2");
        issue(4'd4, 32'd7, 32'd0, 1'b0);
        expect_fall("divu_by_zero", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 8'd10);
        wait_idle("divu_by_zero");
        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        expect_fall("div_overflow", 32'h0, 32'h8000_0000, 8'd10);
        wait_idle("div_overflow");
        issue(4'd3, 32'd7, 32'hFFFF_FFFE, 1'b0);
        expect_fall("div_7_m2", 32'h0000_0001, 32'hFFFF_FFFD, 8'd10);
        wait_idle("div_7_m2");
        issue(4'd4, 32'd100, 32'd7, 1'b0);
        expect_fall("divu_100_7", 32'h0000_0002, 32'h0000_000E, 8'd10);
        wait_idle("divu_100_7");
        issue(4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        expect_fall("mult_m1xm1", 32'h0, 32'h0000_0001, 8'd5);
        wait_idle("mult_m1xm1");

        // While busy: an mthi is ignored and a flush does not cancel the op.
        issue(4'd1, 32'd2, 32'd3, 1'b0);
        expect_fall("mult_busy_ignore", 32'h0, 32'h0000_0006, 8'd5);
        issue(4'd5, 32'h0000_9999, 32'h0, 1'b0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        wait_idle("mult_busy_ignore");

        issue(4'd5, 32'h0000_1234, 32'h0, 1'b1);
        expect_snap("mthi_flushed", 32'h0, 32'h0000_0006);
        issue(4'd5, 32'h0000_1234, 32'h0, 1'b0);
        expect_snap("mthi_1234", 32'h0000_1234, 32'h0000_0006);
        issue(4'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        expect_snap("op0_noop", 32'h0000_1234, 32'h0000_0006);
        issue(4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        expect_snap("op9_noop", 32'h0000_1234, 32'h0000_0006);
        issue(4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        expect_snap("op15_noop", 32'h0000_1234, 32'h0000_0006);

`ifdef MDU_MADD_EN
        issue(4'd6, 32'd10, 32'h0, 1'b0);
        expect_snap("mtlo_10", 32'h0000_1234, 32'd10);
        issue(4'd5, 32'd0, 32'h0, 1'b0);
        expect_snap("mthi_0", 32'h0, 32'd10);
        issue(4'd7, 32'd3, 32'd4, 1'b0);
        expect_fall("madd_3x4", 32'h0, 32'd22, 8'd5);
        wait_idle("madd_3x4");
        issue(4'd8, 32'd1, 32'd23, 1'b0);
        expect_fall("msub_1x23", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'd5);
        wait_idle("msub_1x23");
`else
        issue(4'd7, 32'd3, 32'd4, 1'b0);
        expect_snap("op7_noop", 32'h0000_1234, 32'h0000_0006);
        issue(4'd8, 32'd1, 32'd23, 1'b0);
        expect_snap("op8_noop", 32'h0000_1234, 32'h0000_0006);
`endif

        repeat (5) @(posedge clk);
        #1;
        tests++;
        if (fall_q.size() != 0 || snap_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d commit and %0d snapshot entries pending, required 0",
                     fall_q.size(), snap_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
